instr_sequencer: RTL and testbench

- Multi-cycle issue/writeback controller that sits between the instruction source (switch word or a future fetch unit) and the register bank plus ALU.
- Accepts one 16-bit instruction per valid/ready handshake and decodes it into register addresses, opcode and zero-extended immediate.
- Sequences bank read, ALU execute and bank writeback as separate states, so results are written back exactly once per instruction.
- Replaces ad-hoc per-clock decoding with a deterministic, handshaked sequence.

---
 rtl/seq_pkg.sv | 37 +++
 rtl/instr_sequencer.sv | 111 +++++++++++
 tb/tb_instr_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// Opcode map, instruction field ranges and FSM state encoding.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    READ,
    EXEC,
    WRITE
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_SUBI = 4'd7;
  localparam logic [3:0] OP_SHLI = 4'd8;
  localparam logic [3:0] OP_SHRI = 4'd9;
  localparam logic [3:0] OP_LDI  = 4'd10;
  localparam logic [3:0] OP_LAST = OP_LDI;

  localparam logic [3:0] IMM_FIRST = OP_ADDI;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RC_HI  = 11;
  localparam int RC_LO  = 8;
  localparam int RA_HI  = 7;
  localparam int RA_LO  = 4;
  localparam int RB_HI  = 3;
  localparam int RB_LO  = 0;

endpackage

// File: rtl/instr_sequencer.sv
// Handshaked issue/writeback controller: decode, bank read,
// ALU wait and a single writeback per accepted instruction.
module instr_sequencer #(
  parameter int ALU_LAT = 1,
  parameter int NUM_OPS = 11
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [4:0]  reg_a,
  output logic [4:0]  reg_b,
  output logic [4:0]  reg_c,
  output logic        bank_rw,
  output logic [15:0] bank_data,
  output logic [4:0]  alu_op,
  output logic [15:0] alu_imm,
  input  logic [15:0] alu_result,
  output logic        busy,
  output logic        illegal,
  output logic [15:0] retired
);

  import seq_pkg::*;

  localparam int CW =
    (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'(ALU_LAT - 1);

  state_t        state;
  logic [15:0]   ir;
  logic [CW-1:0] cnt;
  logic          bank_rw_q;
  logic [3:0]    opc;

  assign opc  = ir[OPC_HI:OPC_LO];
  assign busy = (state != IDLE);

  // Kill a write that is in flight while reset is held.
  assign bank_rw = bank_rw_q & ~reset;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      ir          <= '0;
      cnt         <= '0;
      instr_ready <= 1'b1;
      reg_a       <= '0;
      reg_b       <= '0;
      reg_c       <= '0;
      bank_rw_q   <= 1'b0;
      bank_data   <= '0;
      alu_op      <= '0;
      alu_imm     <= '0;
      illegal     <= 1'b0;
      retired     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (instr_valid) begin
            ir          <= instr;
            instr_ready <= 1'b0;
            state       <= DECODE;
          end
        end
        DECODE: begin
          alu_op <= {1'b0, opc};
          reg_c  <= {1'b0, ir[RC_HI:RC_LO]};
          reg_b  <= {1'b0, ir[RB_HI:RB_LO]};
          if ({1'b0, opc} >= 5'(NUM_OPS)) begin
            illegal     <= 1'b1;
            instr_ready <= 1'b1;
            state       <= IDLE;
          end else begin
            if (opc >= IMM_FIRST) begin
              reg_a   <= '0;
              alu_imm <= {12'b0, ir[RA_HI:RA_LO]};
            end else begin
              reg_a   <= {1'b0, ir[RA_HI:RA_LO]};
              alu_imm <= '0;
            end
            state <= READ;
          end
        end
        READ: begin
          cnt   <= CNT_INIT;
          state <= EXEC;
        end
        EXEC: begin
          if (cnt == '0) begin
            bank_rw_q <= 1'b1;
            bank_data <= alu_result;
            state     <= WRITE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WRITE: begin
          bank_rw_q   <= 1'b0;
          retired     <= retired + 16'd1;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer at ALU_LAT=1 and ALU_LAT=3
// with a write scoreboard per instance.
module tb_instr_sequencer;

  typedef struct {
    int          e;
    logic [4:0]  rc;
    logic [15:0] data;
  } wr_t;

  logic        clk;
  int          cyc;
  int          n_assert;
  int          n_fail;

  logic [1:0]  rst;
  logic [1:0]  vld;
  logic [15:0] ins   [2];
  logic        rdy   [2];
  logic [4:0]  reg_a [2];
  logic [4:0]  reg_b [2];
  logic [4:0]  reg_c [2];
  logic        rw    [2];
  logic [15:0] bdata [2];
  logic [4:0]  aop   [2];
  logic [15:0] aimm  [2];
  logic [15:0] stub  [2];
  logic        bsy   [2];
  logic        ill   [2];
  logic [15:0] ret   [2];

  wr_t q0[$];
  wr_t q1[$];
  wr_t x0;
  wr_t x1;

  instr_sequencer #(.ALU_LAT(1), .NUM_OPS(11)) dut1 (
    .CLOCK_50(clk), .reset(rst[0]),
    .instr(ins[0]), .instr_valid(vld[0]),
    .instr_ready(rdy[0]),
    .reg_a(reg_a[0]), .reg_b(reg_b[0]), .reg_c(reg_c[0]),
    .bank_rw(rw[0]), .bank_data(bdata[0]),
    .alu_op(aop[0]), .alu_imm(aimm[0]),
    .alu_result(stub[0]),
    .busy(bsy[0]), .illegal(ill[0]), .retired(ret[0])
  );

  instr_sequencer #(.ALU_LAT(3), .NUM_OPS(11)) dut3 (
    .CLOCK_50(clk), .reset(rst[1]),
    .instr(ins[1]), .instr_valid(vld[1]),
    .instr_ready(rdy[1]),
    .reg_a(reg_a[1]), .reg_b(reg_b[1]), .reg_c(reg_c[1]),
    .bank_rw(rw[1]), .bank_data(bdata[1]),
    .alu_op(aop[1]), .alu_imm(aimm[1]),
    .alu_result(stub[1]),
    .busy(bsy[1]), .illegal(ill[1]), .retired(ret[1])
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_edge(input int e);
    int n;
    n = 0;
    while (cyc < e && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic accept(input int d,
                        input logic [15:0] w,
                        output int t);
    int n;
    vld[d] = 1'b1;
    ins[d] = w;
    n = 0;
    while (rdy[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 50), 32'd1);
    t = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    vld[d] = 1'b0;
    ins[d] = 16'hDEAD;
  endtask

  task automatic chk_reset(input int d);
    chk("rst_ready",   32'(rdy[d]),   32'd1);
    chk("rst_busy",    32'(bsy[d]),   32'd0);
    chk("rst_reg_a",   32'(reg_a[d]), 32'd0);
    chk("rst_reg_b",   32'(reg_b[d]), 32'd0);
    chk("rst_reg_c",   32'(reg_c[d]), 32'd0);
    chk("rst_bank_rw", 32'(rw[d]),    32'd0);
    chk("rst_bdata",   32'(bdata[d]), 32'd0);
    chk("rst_alu_op",  32'(aop[d]),   32'd0);
    chk("rst_alu_imm", 32'(aimm[d]),  32'd0);
    chk("rst_illegal", 32'(ill[d]),   32'd0);
    chk("rst_retired", 32'(ret[d]),   32'd0);
  endtask

  task automatic chk_fields(input int d,
                            input int rc, input int ra,
                            input int rb, input int op,
                            input int imm);
    chk("dec_reg_c",   32'(reg_c[d]), 32'(rc));
    chk("dec_reg_a",   32'(reg_a[d]), 32'(ra));
    chk("dec_reg_b",   32'(reg_b[d]), 32'(rb));
    chk("dec_alu_op",  32'(aop[d]),   32'(op));
    chk("dec_alu_imm", 32'(aimm[d]),  32'(imm));
  endtask

  always @(negedge clk) begin
    if (rw[0] === 1'b1) begin
      n_assert++;
      assert (q0.size() != 0) else begin
        n_fail++;
        $error("FAIL wr0_unexpected observed=write expected=none cyc=%0d", cyc);
      end
      if (q0.size() != 0) begin
        x0 = q0.pop_front();
        chk("wr0_cycle", 32'(cyc),      32'(x0.e));
        chk("wr0_addr",  32'(reg_c[0]), 32'(x0.rc));
        chk("wr0_data",  32'(bdata[0]), 32'(x0.data));
      end
    end
  end

  always @(negedge clk) begin
    if (rw[1] === 1'b1) begin
      n_assert++;
      assert (q1.size() != 0) else begin
        n_fail++;
        $error("FAIL wr1_unexpected observed=write expected=none cyc=%0d", cyc);
      end
      if (q1.size() != 0) begin
        x1 = q1.pop_front();
        chk("wr1_cycle", 32'(cyc),      32'(x1.e));
        chk("wr1_addr",  32'(reg_c[1]), 32'(x1.rc));
        chk("wr1_data",  32'(bdata[1]), 32'(x1.data));
      end
    end
  end

  initial begin
    int t;
    int t2;
    int n;
    n_assert = 0;
    n_fail   = 0;
    rst      = 2'b11;
    vld      = 2'b00;
    ins[0]   = '0;
    ins[1]   = '0;
    stub[0]  = '0;
    stub[1]  = '0;

    repeat (2) @(posedge clk);
    #1 rst = 2'b00;
    @(negedge clk);
    chk_reset(0);
    chk_reset(1);

    // R-type, one-cycle ALU
    stub[0] = 16'h0042;
    q0.push_back('{e: cyc + 4, rc: 5'd3, data: 16'h0042});
    accept(0, 16'h0312, t);
    chk("rt_ready_drop", 32'(rdy[0]), 32'd0);
    chk("rt_busy",       32'(bsy[0]), 32'd1);
    wait_edge(t + 1);
    chk_fields(0, 3, 1, 2, 0, 0);
    wait_edge(t + 3);
    chk("rt_ready_low", 32'(rdy[0]), 32'd0);
    wait_edge(t + 4);
    chk("rt_ready_back", 32'(rdy[0]), 32'd1);
    chk("rt_retired",    32'(ret[0]), 32'd1);
    chk("rt_idle",       32'(bsy[0]), 32'd0);
    chk("rt_rw_off",     32'(rw[0]),  32'd0);

    // immediate form
    stub[0] = 16'hBEEF;
    q0.push_back('{e: cyc + 4, rc: 5'hA, data: 16'hBEEF});
    accept(0, 16'h6A9B, t);
    wait_edge(t + 1);
    chk_fields(0, 10, 0, 11, 6, 9);
    wait_edge(t + 4);
    chk("imm_ready", 32'(rdy[0]), 32'd1);
    chk("imm_retired", 32'(ret[0]), 32'd2);

    // illegal opcode, then a legal one
    accept(0, 16'hF123, t);
    chk("ill_not_yet", 32'(ill[0]), 32'd0);
    wait_edge(t + 1);
    chk("ill_flag",    32'(ill[0]), 32'd1);
    chk("ill_ready",   32'(rdy[0]), 32'd1);
    chk("ill_idle",    32'(bsy[0]), 32'd0);
    wait_edge(t + 4);
    chk("ill_retired", 32'(ret[0]), 32'd2);
    stub[0] = 16'h0777;
    q0.push_back('{e: cyc + 4, rc: 5'd3, data: 16'h0777});
    accept(0, 16'h2345, t);
    wait_edge(t + 1);
    chk_fields(0, 3, 4, 5, 2, 0);
    wait_edge(t + 4);
    chk("post_ill_retired", 32'(ret[0]), 32'd3);
    chk("ill_sticky",       32'(ill[0]), 32'd1);

    // reset during WRITE
    stub[0] = 16'h5555;
    accept(0, 16'h0123, t);
    wait_edge(t + 2);
    @(posedge clk);
    #1 rst[0] = 1'b1;
    @(negedge clk);
    chk("rw_supp_bank_rw", 32'(rw[0]),  32'd0);
    chk("rw_supp_busy",    32'(bsy[0]), 32'd1);
    chk("rw_supp_retired", 32'(ret[0]), 32'd3);
    @(posedge clk);
    #1 rst[0] = 1'b0;
    @(negedge clk);
    chk_reset(0);
    repeat (4) @(negedge clk);
    chk("rw_supp_ret_hold", 32'(ret[0]), 32'd0);

    // back-to-back, three-cycle ALU, valid held high
    stub[1] = 16'h1111;
    vld[1]  = 1'b1;
    ins[1]  = 16'h1456;
    t = cyc + 1;
    q1.push_back('{e: t + 5,  rc: 5'd4, data: 16'h1111});
    q1.push_back('{e: t + 12, rc: 5'd7, data: 16'h2222});
    @(posedge clk);
    @(negedge clk);
    ins[1] = 16'h2789;
    chk("b2b_ready_drop", 32'(rdy[1]), 32'd0);
    n = 0;
    while (rdy[1] !== 1'b1 && n < 40) begin
      if (cyc == t + 1) chk_fields(1, 4, 5, 6, 1, 0);
      if (cyc == t + 5) stub[1] = 16'h2222;
      @(negedge clk);
      n++;
    end
    chk("b2b_timeout", 32'(n < 40), 32'd1);
    t2 = cyc + 1;
    chk("b2b_second_accept", 32'(t2), 32'(t + 7));
    chk("b2b_retired_1",     32'(ret[1]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    vld[1] = 1'b0;
    ins[1] = 16'hFEDC;
    wait_edge(t2 + 1);
    chk_fields(1, 7, 8, 9, 2, 0);
    wait_edge(t2 + 6);
    chk("b2b_ready_back", 32'(rdy[1]), 32'd1);
    chk("b2b_retired_2",  32'(ret[1]), 32'd2);
    chk("b2b_illegal",    32'(ill[1]), 32'd0);

    repeat (4) @(negedge clk);
    chk("sb0_drained", 32'(q0.size()), 32'd0);
    chk("sb1_drained", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
